// File: rtl/addsub_accumulator.sv
// Handshaked sequencer and result register around an external 4-bit adder/subtractor.
// Optional build macro ADDSUB_SATURATE_EN clamps acc on unsigned carry/borrow.
module addsub_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  output logic             as_subt,
  input  logic [WIDTH-1:0] as_sum,
  input  logic             as_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             ovf_sticky
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [1:0]       state, state_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH-1:0] acc_r, acc_nxt;
  logic             carry_r, carry_nxt;
  logic             ovf_r, ovf_nxt;
  logic             sticky_r, sticky_nxt;
  logic             ovf_add, ovf_sub;
  logic             exec;

  assign exec      = (state == EXEC);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The adder only sees the operand while executing; otherwise b/subt rest at zero.
  assign as_a    = acc_r;
  assign as_b    = exec ? opnd_r : '0;
  assign as_subt = exec && (op_r == OP_SUB);

  assign ovf_add = (acc_r[WIDTH-1] == opnd_r[WIDTH-1]) && (as_sum[WIDTH-1] != acc_r[WIDTH-1]);
  assign ovf_sub = (acc_r[WIDTH-1] != opnd_r[WIDTH-1]) && (as_sum[WIDTH-1] != acc_r[WIDTH-1]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_nxt    = acc_r;
    carry_nxt  = carry_r;
    ovf_nxt    = ovf_r;
    sticky_nxt = sticky_r;
    if (exec) begin
      case (op_r)
        OP_LOAD: begin
          acc_nxt   = opnd_r;
          carry_nxt = 1'b0;
          ovf_nxt   = 1'b0;
        end
        OP_ADD: begin
`ifdef ADDSUB_SATURATE_EN
          acc_nxt    = as_cout ? '1 : as_sum;
`else
          acc_nxt    = as_sum;
`endif
          carry_nxt  = as_cout;
          ovf_nxt    = ovf_add;
          sticky_nxt = sticky_r | ovf_add;
        end
        OP_SUB: begin
`ifdef ADDSUB_SATURATE_EN
          acc_nxt    = as_cout ? as_sum : '0;
`else
          acc_nxt    = as_sum;
`endif
          carry_nxt  = as_cout;
          ovf_nxt    = ovf_sub;
          sticky_nxt = sticky_r | ovf_sub;
        end
        default: begin
          acc_nxt    = '0;
          carry_nxt  = 1'b0;
          ovf_nxt    = 1'b0;
          sticky_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_r     <= OP_LOAD;
      opnd_r   <= '0;
      acc_r    <= '0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc_r    <= acc_nxt;
      carry_r  <= carry_nxt;
      ovf_r    <= ovf_nxt;
      sticky_r <= sticky_nxt;
      if (in_ready && in_valid) begin
        op_r   <= in_op;
        opnd_r <= in_data;
      end
    end
  end

  assign acc        = acc_r;
  assign carry      = carry_r;
  assign ovf        = ovf_r;
  assign ovf_sticky = sticky_r;
  assign zero       = (acc_r == '0);

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator; includes a behavioural 4-bit adder/subtractor.
module tb_addsub_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic [3:0] as_a, as_b, as_sum;
  logic       as_subt, as_cout;
  logic       out_valid, out_ready;
  logic [3:0] acc;
  logic       carry, zero, ovf, ovf_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_accumulator #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .as_a(as_a), .as_b(as_b), .as_subt(as_subt), .as_sum(as_sum), .as_cout(as_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .carry(carry), .zero(zero), .ovf(ovf), .ovf_sticky(ovf_sticky)
  );

  // External adder/subtractor: subtract as a + ~b + 1, so cout=1 means no borrow.
  logic [4:0] ext;
  always_comb begin
    ext = '0;
    if (as_subt) ext = {1'b0, as_a} + {1'b0, ~as_b} + 5'd1;
    else         ext = {1'b0, as_a} + {1'b0, as_b};
  end
  assign as_sum  = ext[3:0];
  assign as_cout = ext[4];

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] acc;
    logic       c;
    logic       o;
    logic       s;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Issue one op and return just after the capture edge (state DONE).
  task automatic do_op(input logic [1:0] op, input logic [3:0] data);
    @(negedge clk);
    chk("idle_in_ready", {7'd0, in_ready}, 8'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("exec_out_valid", {7'd0, out_valid}, 8'd0);
    chk("exec_in_ready", {7'd0, in_ready}, 8'd0);
    chk("exec_as_b", {4'd0, as_b}, {4'd0, data});
    chk("exec_as_subt", {7'd0, as_subt}, {7'd0, op == 2'b10});
    @(posedge clk); #1;
    chk("done_out_valid", {7'd0, out_valid}, 8'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    //          op     data   acc    c     o     s
    tbl[0]  = '{2'b00, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 4'h3, 4'h8, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{2'b01, 4'h1, 4'h9, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{2'b11, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'b00, 4'h9, 4'h9, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SATURATE_EN
    tbl[5]  = '{2'b01, 4'h9, 4'hF, 1'b1, 1'b1, 1'b1};
`else
    tbl[5]  = '{2'b01, 4'h9, 4'h2, 1'b1, 1'b1, 1'b1};
`endif
    tbl[6]  = '{2'b11, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{2'b00, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SATURATE_EN
    tbl[8]  = '{2'b10, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0};
`else
    tbl[8]  = '{2'b10, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
`endif
    tbl[9]  = '{2'b00, 4'h8, 4'h8, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'b10, 4'h1, 4'h7, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{2'b00, 4'h2, 4'h2, 1'b0, 1'b0, 1'b1};
`ifdef ADDSUB_SATURATE_EN
    tbl[12] = '{2'b01, 4'hE, 4'hF, 1'b1, 1'b0, 1'b1};
`else
    tbl[12] = '{2'b01, 4'hE, 4'h0, 1'b1, 1'b0, 1'b1};
`endif
    tbl[13] = '{2'b11, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = 4'h0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_acc", {4'd0, acc}, 8'd0);
    chk("rst_zero", {7'd0, zero}, 8'd1);
    chk("rst_carry", {7'd0, carry}, 8'd0);
    chk("rst_ovf", {7'd0, ovf}, 8'd0);
    chk("rst_sticky", {7'd0, ovf_sticky}, 8'd0);
    chk("rst_as_b", {4'd0, as_b}, 8'd0);
    chk("rst_as_subt", {7'd0, as_subt}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i].op, tbl[i].data);
      chk($sformatf("v%0d_acc", i), {4'd0, acc}, {4'd0, tbl[i].acc});
      chk($sformatf("v%0d_carry", i), {7'd0, carry}, {7'd0, tbl[i].c});
      chk($sformatf("v%0d_ovf", i), {7'd0, ovf}, {7'd0, tbl[i].o});
      chk($sformatf("v%0d_sticky", i), {7'd0, ovf_sticky}, {7'd0, tbl[i].s});
      chk($sformatf("v%0d_zero", i), {7'd0, zero}, {7'd0, tbl[i].acc == 4'h0});
      chk($sformatf("v%0d_done_as_b", i), {4'd0, as_b}, 8'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_release_vld", i), {7'd0, out_valid}, 8'd0);
      chk($sformatf("v%0d_release_rdy", i), {7'd0, in_ready}, 8'd1);
    end

    // Backpressure: result held while out_ready low; pending ADD waits.
    do_op(2'b00, 4'h7);
    @(posedge clk); #1;
    @(negedge clk);
    out_ready = 1'b0;
    do_op(2'b10, 4'h7);
    chk("bp_acc", {4'd0, acc}, 8'd0);
    chk("bp_zero", {7'd0, zero}, 8'd1);
    chk("bp_carry", {7'd0, carry}, 8'd1);
    chk("bp_ovf", {7'd0, ovf}, 8'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 4'h1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_vld", k), {7'd0, out_valid}, 8'd1);
      chk($sformatf("bp_hold%0d_rdy", k), {7'd0, in_ready}, 8'd0);
      chk($sformatf("bp_hold%0d_acc", k), {4'd0, acc}, 8'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_vld", {7'd0, out_valid}, 8'd0);
    chk("bp_rel_rdy", {7'd0, in_ready}, 8'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_acc2_rdy", {7'd0, in_ready}, 8'd0);
    chk("bp_acc2_as_b", {4'd0, as_b}, 8'd1);
    @(posedge clk); #1;
    chk("bp_add_vld", {7'd0, out_valid}, 8'd1);
    chk("bp_add_acc", {4'd0, acc}, 8'd1);
    chk("bp_add_carry", {7'd0, carry}, 8'd0);
    @(posedge clk); #1;

    // Reset during EXEC discards the op.
    do_op(2'b00, 4'h6);
    @(posedge clk); #1;
    do_op(2'b01, 4'h3);
    chk("pre_rst_sticky", {7'd0, ovf_sticky}, 8'd1);
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 4'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_exec_rdy", {7'd0, in_ready}, 8'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {7'd0, out_valid}, 8'd0);
    chk("mid_rst_rdy", {7'd0, in_ready}, 8'd1);
    chk("mid_rst_acc", {4'd0, acc}, 8'd0);
    chk("mid_rst_zero", {7'd0, zero}, 8'd1);
    chk("mid_rst_sticky", {7'd0, ovf_sticky}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_vld", {7'd0, out_valid}, 8'd0);
    chk("post_rst_acc", {4'd0, acc}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
